// File: rtl/clock_timekeeper.sv
//------------------------------------------------------------------------------
// clock_timekeeper: HMS timekeeper with button editing, repeat and idle timeout;
// optional edited-field blinking via CLOCK_TIMEKEEPER_BLINK_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module clock_timekeeper #(
  parameter int H24            = 1,
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_PERIOD  = 10_000_000,
  parameter int IDLE_TIMEOUT_S = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_1hz,
  input  logic       mode_button,
  input  logic       add_button,
  input  logic       sub_button,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       pm,
  output logic [1:0] edit_field,
  output logic [2:0] blank
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int IDLE_W  = (IDLE_TIMEOUT_S > 1) ? $clog2(IDLE_TIMEOUT_S + 1) : 1;
  localparam logic [REP_W-1:0]  DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]  PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(IDLE_TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2,
    SET_SECONDS = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              mode_q, add_q, sub_q;
  logic [4:0]        hours, hours_next;
  logic [5:0]        minutes, minutes_next;
  logic [5:0]        seconds, seconds_next;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_next;
  logic              rep_active, rep_active_next;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_next;
  logic              rep_step, step_up, step_dn;
  logic [4:0]        disp_hours;

  logic mode_edge, add_edge, sub_edge, btn_edge, one_held, any_held, in_set;
  assign mode_edge = mode_button & ~mode_q;
  assign add_edge  = add_button & ~add_q;
  assign sub_edge  = sub_button & ~sub_q;
  assign btn_edge  = mode_edge | add_edge | sub_edge;
  assign one_held  = add_button ^ sub_button;
  assign any_held  = add_button | sub_button;
  assign in_set    = (state != RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      mode_q     <= 1'b0;
      add_q      <= 1'b0;
      sub_q      <= 1'b0;
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      rep_cnt    <= '0;
      rep_active <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_next;
      mode_q     <= mode_button;
      add_q      <= add_button;
      sub_q      <= sub_button;
      hours      <= hours_next;
      minutes    <= minutes_next;
      seconds    <= seconds_next;
      rep_cnt    <= rep_cnt_next;
      rep_active <= rep_active_next;
      idle_cnt   <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    hours_next      = hours;
    minutes_next    = minutes;
    seconds_next    = seconds;
    rep_cnt_next    = rep_cnt;
    rep_active_next = rep_active;
    idle_cnt_next   = idle_cnt;
    rep_step        = 1'b0;
    step_up         = 1'b0;
    step_dn         = 1'b0;

    // rep_cnt counts cycles since the last step; rep_active selects delay vs period
    if (!in_set || btn_edge || !one_held) begin
      rep_cnt_next    = '0;
      rep_active_next = 1'b0;
    end else if (rep_cnt == (rep_active ? PERIOD_LAST : DELAY_LAST)) begin
      rep_cnt_next    = '0;
      rep_active_next = 1'b1;
      rep_step        = 1'b1;
    end else begin
      rep_cnt_next = rep_cnt + 1'b1;
    end

    if (mode_edge) begin
      case (state)
        RUN:         state_next = SET_HOURS;
        SET_HOURS:   state_next = SET_MINUTES;
        SET_MINUTES: state_next = SET_SECONDS;
        default:     state_next = RUN;
      endcase
    end else if (in_set) begin
      if (add_edge ^ sub_edge) begin
        step_up = add_edge;
        step_dn = sub_edge;
      end else if (rep_step) begin
        step_up = add_button;
        step_dn = sub_button;
      end
    end else if (pulse_1hz) begin
      if (seconds == 6'd59) begin
        seconds_next = '0;
        if (minutes == 6'd59) begin
          minutes_next = '0;
          hours_next   = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes_next = minutes + 6'd1;
        end
      end else begin
        seconds_next = seconds + 6'd1;
      end
    end

    case (state)
      SET_HOURS: begin
        if (step_up)      hours_next = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        else if (step_dn) hours_next = (hours == 5'd0) ? 5'd23 : hours - 5'd1;
      end
      SET_MINUTES: begin
        if (step_up)      minutes_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        else if (step_dn) minutes_next = (minutes == 6'd0) ? 6'd59 : minutes - 6'd1;
      end
      SET_SECONDS: begin
        if (step_up)      seconds_next = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
        else if (step_dn) seconds_next = (seconds == 6'd0) ? 6'd59 : seconds - 6'd1;
      end
      default: ;
    endcase

    // mode edges clear idle_cnt, so a timeout never collides with a mode step
    if (!in_set || btn_edge || any_held) begin
      idle_cnt_next = '0;
    end else if ((IDLE_TIMEOUT_S != 0) && pulse_1hz) begin
      if (idle_cnt == IDLE_LAST) begin
        idle_cnt_next = '0;
        state_next    = RUN;
      end else begin
        idle_cnt_next = idle_cnt + 1'b1;
      end
    end
  end

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'b0000} + {2'b00, rem};
  endfunction

  always_comb begin
    if (H24 != 0)              disp_hours = hours;
    else if (hours == 5'd0)    disp_hours = 5'd12;
    else if (hours > 5'd12)    disp_hours = hours - 5'd12;
    else                       disp_hours = hours;
  end

  assign hours_bcd   = to_bcd({1'b0, disp_hours});
  assign minutes_bcd = to_bcd(minutes);
  assign seconds_bcd = to_bcd(seconds);
  assign pm          = (hours >= 5'd12);
  assign edit_field  = state;

`ifdef CLOCK_TIMEKEEPER_BLINK_EN
  logic blink_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                      blink_phase <= 1'b0;
    else if (state_next == RUN || btn_edge || any_held) blink_phase <= 1'b0;
    else if (pulse_1hz)                              blink_phase <= ~blink_phase;
  end

  always_comb begin
    blank = 3'b000;
    case (state)
      SET_HOURS:   blank = {blink_phase, 2'b00};
      SET_MINUTES: blank = {1'b0, blink_phase, 1'b0};
      SET_SECONDS: blank = {2'b00, blink_phase};
      default:     blank = 3'b000;
    endcase
  end
`else
  assign blank = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_timekeeper.sv
//------------------------------------------------------------------------------
// tb_clock_timekeeper: scoreboard bench driving a 24-hour and a 12-hour instance
// with identical stimulus.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_clock_timekeeper;

  localparam int D    = 10;
  localparam int P    = 4;
  localparam int IDLE = 3;
`ifdef CLOCK_TIMEKEEPER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pulse = 1'b0, mode_b = 1'b0, add_b = 1'b0, sub_b = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic       pm24, pm12;
  logic [1:0] f24, f12;
  logic [2:0] b24, b12;

  clock_timekeeper #(.H24(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .IDLE_TIMEOUT_S(IDLE)) dut24 (
    .clock(clk), .reset(reset), .pulse_1hz(pulse), .mode_button(mode_b),
    .add_button(add_b), .sub_button(sub_b), .hours_bcd(h24), .minutes_bcd(m24),
    .seconds_bcd(s24), .pm(pm24), .edit_field(f24), .blank(b24));

  clock_timekeeper #(.H24(0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .IDLE_TIMEOUT_S(IDLE)) dut12 (
    .clock(clk), .reset(reset), .pulse_1hz(pulse), .mode_button(mode_b),
    .add_button(add_b), .sub_button(sub_b), .hours_bcd(h12), .minutes_bcd(m12),
    .seconds_bcd(s12), .pm(pm12), .edit_field(f12), .blank(b12));

  wire [59:0] obs = {h24, h12, m24, s24, pm24, f24, b24, m12, s12, pm12, f12, b12};

  int n_cmp = 0;
  int n_err = 0;
  logic [59:0] exp_q[$];
  int mh = 0, mm = 0, ms = 0, mf = 0, mp = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [59:0] model_vec();
    int         h12v;
    logic [2:0] bl;
    logic       pmv;
    h12v = (mh % 12 == 0) ? 12 : mh % 12;
    pmv  = (mh >= 12);
    bl   = 3'b000;
    if (BLINK) begin
      if (mf == 1)      bl = {mp[0], 2'b00};
      else if (mf == 2) bl = {1'b0, mp[0], 1'b0};
      else if (mf == 3) bl = {2'b00, mp[0]};
    end
    return {bcd(mh), bcd(h12v), bcd(mm), bcd(ms), pmv, 2'(mf), bl,
            bcd(mm), bcd(ms), pmv, 2'(mf), bl};
  endfunction

  task automatic model_tick();
    ms = ms + 1;
    if (ms == 60) begin
      ms = 0;
      mm = mm + 1;
      if (mm == 60) begin
        mm = 0;
        mh = (mh + 1) % 24;
      end
    end
  endtask

  // inputs change on the falling edge; the task returns one falling edge later
  task automatic drive(input logic m, input logic a, input logic s, input logic p);
    mode_b = m; add_b = a; sub_b = s; pulse = p;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [59:0] e;
    @(negedge clk);
    mh = 0; mm = 0; ms = 0; mf = 0; mp = 0;
    exp_q.push_back(model_vec());
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reset_state: got %h exp %h", obs, e); end
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(model_vec());
    drive(0, 0, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL after_release: got %h exp %h", obs, e); end
  endtask

  task automatic test_run_count();
    logic [59:0] e;
    for (int i = 0; i < 3600; i++) begin
      model_tick();
      exp_q.push_back(model_vec());
      drive(0, 0, 0, 1);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL run_tick %0d: got %h exp %h", i + 1, obs, e); end
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_set_hours_12h();
    logic [59:0] e;
    mf = 1; mp = 0;
    exp_q.push_back(model_vec());
    drive(1, 0, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL enter_set_hours: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    mh = 0;
    exp_q.push_back(model_vec());
    drive(0, 0, 1, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL hour_zero: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      mh = (mh + 1) % 24;
      exp_q.push_back(model_vec());
      drive(0, 1, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL hour_add h=%0d: got %h exp %h", mh, obs, e); end
      drive(0, 0, 0, 0);
    end
    mh = 23;
    exp_q.push_back(model_vec());
    drive(0, 0, 1, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL hour_sub_wrap: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_set_minutes();
    logic [59:0] e;
    mf = 2; mp = 0; mm = 0;
    exp_q.push_back(model_vec());
    drive(1, 0, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL enter_set_minutes: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    mm = 59;
    exp_q.push_back(model_vec());
    drive(0, 0, 1, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL minute_sub_wrap: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      mm = (mm + 1) % 60;
      exp_q.push_back(model_vec());
      drive(0, 1, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL minute_add m=%0d: got %h exp %h", mm, obs, e); end
      drive(0, 0, 0, 0);
    end
    mp = 1;
    exp_q.push_back(model_vec());
    drive(0, 0, 0, 1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL pulse_in_set: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_repeat();
    logic [59:0] e;
    mf = 3; mp = 0; ms = 0;
    exp_q.push_back(model_vec());
    drive(1, 0, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL enter_set_seconds: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    // edge cycle plus 30 held cycles: steps at 0, D, D+P, ... -> 7 increments
    for (int j = 0; j <= 30; j++) begin
      if (j == 0 || (j >= D && (j - D) % P == 0)) ms = (ms + 1) % 60;
      exp_q.push_back(model_vec());
      drive(0, 1, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL hold_add cyc %0d: got %h exp %h", j, obs, e); end
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      ms = (ms + 59) % 60;
      exp_q.push_back(model_vec());
      drive(0, 0, 1, 0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL second_sub s=%0d: got %h exp %h", ms, obs, e); end
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic test_priority();
    logic [59:0] e;
    mf = 0; mp = 0;
    exp_q.push_back(model_vec());
    drive(1, 0, 0, 1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL mode_with_pulse: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    model_tick();
    exp_q.push_back(model_vec());
    drive(0, 0, 0, 1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL day_wrap: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    exp_q.push_back(model_vec());
    drive(0, 1, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL add_in_run: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    mf = 1;
    exp_q.push_back(model_vec());
    drive(1, 0, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL enter_hours_2: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    mf = 2;
    exp_q.push_back(model_vec());
    drive(1, 1, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL mode_beats_add: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    exp_q.push_back(model_vec());
    drive(0, 1, 1, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL add_sub_cancel: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      mf = (mf + 1) % 4;
      exp_q.push_back(model_vec());
      drive(1, 0, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL mode_cycle f=%0d: got %h exp %h", mf, obs, e); end
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic test_idle_timeout();
    logic [59:0] e;
    mf = 1; mp = 0;
    exp_q.push_back(model_vec());
    drive(1, 0, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL enter_hours_idle: got %h exp %h", obs, e); end
    for (int k = 1; k <= IDLE; k++) begin
      if (k < IDLE) mp = mp ^ 1;
      else begin mf = 0; mp = 0; end
      exp_q.push_back(model_vec());
      drive(0, 0, 0, 1);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL idle_tick %0d: got %h exp %h", k, obs, e); end
      exp_q.push_back(model_vec());
      drive(0, 0, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL idle_gap %0d: got %h exp %h", k, obs, e); end
    end
    model_tick();
    exp_q.push_back(model_vec());
    drive(0, 0, 0, 1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL resume_after_idle: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_edit();
    logic [59:0] e;
    mf = 1; mp = 0;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    mh = (mh + 1) % 24;
    exp_q.push_back(model_vec());
    drive(0, 1, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL edit_before_reset: got %h exp %h", obs, e); end
    drive(0, 0, 0, 0);
    reset = 1'b0;
    mh = 0; mm = 0; ms = 0; mf = 0; mp = 0;
    exp_q.push_back(model_vec());
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL async_reset: got %h exp %h", obs, e); end
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_count();
    test_set_hours_12h();
    test_set_minutes();
    test_repeat();
    test_priority();
    test_idle_timeout();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_timekeeper.md
# clock_timekeeper

Parametrised timekeeping and time-setting controller for the digital clock, second generation of the front-panel clock interface. It holds hours/minutes/seconds, advances on the 1 Hz tick, and lets the user edit each field through mode/add/sub buttons. New behaviour: 12/24-hour display, hold-to-repeat adjustment, idle timeout back to RUN, and optional blinking of the field being edited. Outputs are packed BCD fields consumed by the seven-segment display driver.

## Interface
- H24, 1: 1 = 24-hour display (00–23); 0 = 12-hour display (12,01–11) with `pm` flag
- REPEAT_DELAY, 50_000_000: cycles add/sub must be held before auto-repeat starts (≥1)
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeat steps (≥1)
- IDLE_TIMEOUT_S, 30: `pulse_1hz` ticks without a button edge in a SET state before returning to RUN; 0 disables
- clock  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- pulse_1hz  in  1  one-cycle pulse at 1 Hz
- mode_button  in  1  level, debounced and synchronous to `clock`
- add_button  in  1  level, debounced, synchronous
- sub_button  in  1  level, debounced, synchronous
- hours_bcd  out  8  {tens,ones} BCD of displayed hour
- minutes_bcd  out  8  {tens,ones} BCD minutes
- seconds_bcd  out  8  {tens,ones} BCD seconds
- pm  out  1  1 when internal hour ≥12 (valid in both modes)
- edit_field  out  2  0 RUN, 1 hours, 2 minutes, 3 seconds
- blank  out  3  {hours,minutes,seconds} blank request for display

## Operation
- Internal time binary: hours 0–23, minutes 0–59, seconds 0–59; BCD/12-hour conversion combinational from these registers.
- Button edges: edge = button & ~button_q (one register per button). Levels used only for hold-to-repeat.
- FSM: RUN → SET_HOURS → SET_MINUTES → SET_SECONDS → RUN, advancing on each mode edge.
- RUN: on `pulse_1hz`, seconds+1 with carry to minutes, hours; 23:59:59 → 00:00:00. add/sub ignored.
- SET states: time does not advance. add edge: selected field +1, wrap at max to 0. sub edge: −1, wrap 0 to max. No carry into other fields.
- Priority in one cycle: mode edge wins, add/sub ignored that cycle; add and sub edges together → neither applied.
- Hold-to-repeat: counter cleared on add/sub edge and when neither or both held; when exactly one held for REPEAT_DELAY cycles, one extra step, then one step every REPEAT_PERIOD cycles while held. Counter cleared on state change.
- Idle timeout: counter of `pulse_1hz` ticks in SET states, cleared on any button edge or held add/sub; reaching IDLE_TIMEOUT_S → RUN, counter cleared. Edited values kept.
- 12-hour map: 0→12, 1–11→same, 12→12, 13–23→1–11.

## Timing
- Reset (asynchronous): state RUN, time 00:00:00, all counters 0. Outputs: hours_bcd 8'h00 (H24=1) or 8'h12 (H24=0), minutes_bcd/seconds_bcd 8'h00, pm 0, edit_field 0, blank 3'b000.
- Every update occurs at the rising edge where its cause is high; outputs reflect it the same cycle after that edge (no extra pipeline).
- Button held from cycle N: edge at N; first repeat step at N+REPEAT_DELAY, then every REPEAT_PERIOD.
- Reset asserted mid-edit returns immediately to reset values; no partial edit survives.
- `pulse_1hz` coincident with mode edge leaving SET_SECONDS: not counted (RUN counting begins next tick).

## Configuration
- CLOCK_TIMEKEEPER_BLINK_EN defined: blink phase flop toggles on each `pulse_1hz` in SET states, forced 0 on any button edge, held add/sub, or in RUN; blank bit of edited field = phase, other bits 0.
- Undefined: no phase flop; `blank` tied to 3'b000.

## Test plan
- Reset, H24=1, 86400 `pulse_1hz` in RUN → wraps to 00:00:00; at 3599 ticks shows 00/59/59, next tick 01/00/00.
- H24=0, set hours to 0,12,13 → hours_bcd 8'h12/pm 0, 8'h12/pm 1, 8'h01/pm 1.
- SET_MINUTES at 00, one sub edge → 59; 60 add edges → 59; hours unchanged; `pulse_1hz` ignored.
- Hold add in SET_SECONDS (REPEAT_DELAY=10, REPEAT_PERIOD=4) for 30 cycles → 1+1+5 = 7 increments.
- Mode and add edges same cycle in SET_HOURS → state SET_MINUTES, hours unchanged; add+sub together → no change.
- IDLE_TIMEOUT_S=3, enter SET_HOURS, 3 ticks no buttons → edit_field 0, time resumes; with BLINK_EN, blank toggles 3'b100/000 per tick before timeout.
